// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue path: alu_op classes, ALU control codes,
// issue-FIFO occupancy states and the buffered entry layout.
package alu_issue_stage_pkg;

  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    CTRL_AND     = 4'b0000,
    CTRL_OR      = 4'b0001,
    CTRL_ADD     = 4'b0010,
    CTRL_SUB     = 4'b0100,
    CTRL_SLL     = 4'b1001,
    CTRL_SRL     = 4'b1010,
    CTRL_ILLEGAL = 4'b1111
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } fifo_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    ctrl_e       ctrl;
    logic        illegal;
  } issue_entry_t;

  function automatic logic is_shift(input ctrl_e c);
    return (c == CTRL_SLL) || (c == CTRL_SRL);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute issue bus: upstream operation fields, flush, and the
// downstream operand/control handshake.
interface alu_issue_stage_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [31:0]      rs1_val;
  logic [31:0]      rs2_val;
  logic [31:0]      imm;
  logic             alu_src;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [3:0]       ctrl;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output in_valid, alu_op, funct3, funct7_5, rs1_val, rs2_val, imm, alu_src,
           flush, out_ready,
    input  in_ready, out_valid, A, B, ctrl, illegal, illegal_count
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7_5, rs1_val, rs2_val, imm, alu_src,
           flush, out_ready,
    output in_ready, out_valid, A, B, ctrl, illegal, illegal_count
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode from alu_op / funct3 / funct7 bit 30.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] ctrl,
  output logic       illegal
);

  // Map the operation class and funct fields onto a control code.
  always_comb begin
    ctrl = CTRL_ILLEGAL;
    case (alu_op_e'(alu_op))
      OP_MEM:    ctrl = CTRL_ADD;
      OP_BRANCH: ctrl = CTRL_SUB;
      OP_RTYPE, OP_ITYPE: begin
        case (funct3)
          3'b000: ctrl = ((alu_op_e'(alu_op) == OP_RTYPE) && funct7_5) ? CTRL_SUB : CTRL_ADD;
          3'b111: ctrl = CTRL_AND;
          3'b110: ctrl = CTRL_OR;
          3'b001: ctrl = CTRL_SLL;
          3'b101: if (!funct7_5) ctrl = CTRL_SRL;
          default: ctrl = CTRL_ILLEGAL;
        endcase
      end
      default: ctrl = CTRL_ILLEGAL;
    endcase
    illegal = (ctrl == CTRL_ILLEGAL);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes operations, selects operands and buffers them in a
// two-entry skid FIFO towards execute; counts accepted illegal operations.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  alu_issue_stage_if.slave  bus
);

  fifo_state_e      state, state_next;
  issue_entry_t     head, tail, new_entry;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_ctrl;
  logic             dec_illegal;
  logic [31:0]      b_raw;
  logic             accept, pop, out_valid;

  alu_ctrl_decode u_decode (
    .alu_op   (bus.alu_op),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal)
  );

  // Build the entry to enqueue: operand select, shift-amount clamp, illegal zeroing.
  always_comb begin
    b_raw             = bus.alu_src ? bus.imm : bus.rs2_val;
    new_entry.ctrl    = ctrl_e'(dec_ctrl);
    new_entry.illegal = dec_illegal;
    new_entry.a       = dec_illegal ? '0 : bus.rs1_val;
    if (dec_illegal)
      new_entry.b = '0;
    else if (is_shift(ctrl_e'(dec_ctrl)))
      new_entry.b = {27'b0, b_raw[4:0]};
    else
      new_entry.b = b_raw;
  end

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = out_valid && bus.out_ready;

  // State register plus registered in_ready derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_TWO);
    end
  end

  // Next-state logic; flush overrides any concurrent accept or pop.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state_next = ST_TWO;
          else if (!accept && pop) state_next = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Entry storage: head feeds the outputs, tail is the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (!bus.flush) begin
      case (state)
        ST_EMPTY: if (accept) head <= new_entry;
        ST_ONE: begin
          if (accept && pop) head <= new_entry;
          else if (accept)   tail <= new_entry;
        end
        ST_TWO:   if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  // Saturating count of accepted illegal operations; flush voids the accept.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (accept && !bus.flush && dec_illegal && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  // Output decode: head entry when valid, zeros otherwise.
  always_comb begin
    out_valid   = (state != ST_EMPTY);
    bus.A       = out_valid ? head.a       : '0;
    bus.B       = out_valid ? head.b       : '0;
    bus.ctrl    = out_valid ? head.ctrl    : '0;
    bus.illegal = out_valid ? head.illegal : 1'b0;
  end

  assign bus.out_valid     = out_valid;
  assign bus.in_ready      = in_ready_q;
  assign bus.illegal_count = cnt;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter CNT_W, default 8, width of the illegal-operation counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 in_valid  in  1  upstream (decode) presents a valid operation.
REQ-005 in_ready  out  1  stage can accept; registered output.
REQ-006 alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-007 funct3  in  3  instruction funct3.
REQ-008 funct7_5  in  1  instruction bit 30.
REQ-009 rs1_val, rs2_val, imm  in  32 each  register operands, sign-extended immediate.
REQ-010 alu_src  in  1  1 = B operand from imm, 0 = from rs2_val.
REQ-011 flush  in  1  discard all buffered operations.
REQ-012 out_valid  out  1  A/B/ctrl hold a valid operation for the ALU.
REQ-013 out_ready  in  1  downstream (execute) consumes the head entry.
REQ-014 A, B  out  32 each  ALU operands; ctrl  out  4  ALU control code.
REQ-015 illegal  out  1  head entry was an undecodable operation.
REQ-016 illegal_count  out  CNT_W  saturating count of accepted illegal operations.

Function
REQ-017 Control codes: AND 0000, OR 0001, ADD 0010, SUB 0100, SLL 1001, SRL 1010, ILLEGAL 1111.
REQ-018 alu_op 00 -> ADD; alu_op 01 -> SUB; funct fields ignored.
REQ-019 alu_op 10: f3 000 -> ADD (f7_5=0) / SUB (f7_5=1); 111 AND; 110 OR; 001 SLL; 101 SRL only if f7_5=0; all else ILLEGAL.
REQ-020 alu_op 11: f3 000 ADD; 111 AND; 110 OR; 001 SLL; 101 SRL only if f7_5=0; all else ILLEGAL (no SUB-immediate).
REQ-021 A = rs1_val; B = alu_src ? imm : rs2_val.
REQ-022 For SLL/SRL, B forced to {27'b0, B[4:0]} so shift amount never exceeds 31.
REQ-023 ILLEGAL entries: ctrl 1111, A=B=0, illegal=1; still passed downstream in order.
REQ-024 Two-entry FIFO (skid buffer); states EMPTY, ONE, TWO.
REQ-025 Accept when in_valid && in_ready; pop when out_valid && out_ready.
REQ-026 in_ready = 1 in EMPTY and ONE, 0 in TWO; never combinationally dependent on out_ready.
REQ-027 Latency: operation accepted in cycle N is on outputs with out_valid=1 in cycle N+1 (from EMPTY).
REQ-028 Transitions: EMPTY+accept->ONE; ONE+accept-only->TWO; ONE+pop-only->EMPTY; ONE+accept+pop->ONE (new entry becomes head); TWO+pop->ONE; else hold.
REQ-029 Outputs A/B/ctrl/illegal stable while out_valid && !out_ready.
REQ-030 When out_valid=0, A, B, ctrl driven 0.
REQ-031 flush: next state EMPTY, concurrent accept and pop are void; illegal_count unaffected.
REQ-032 illegal_count increments on each accepted ILLEGAL entry; saturates at 2^CNT_W-1.

Reset
REQ-033 rst has priority over flush and all handshakes.
REQ-034 After reset: state EMPTY, out_valid=0, in_ready=1, A=B=0, ctrl=0000, illegal=0, illegal_count=0.
REQ-035 Reset mid-operation discards both entries with no output pulse.

Structure
REQ-036 Shared package holds the 4-bit ctrl code constants and the 2-bit alu_op encoding, also used by the ALU and decoder.
REQ-037 Decode is one combinational sub-module alu_ctrl_decode (alu_op, funct3, funct7_5 -> ctrl, illegal); FIFO and counter are in alu_issue_stage.

Verification
REQ-038 Reset then in_valid=1, alu_op=10, f3=000, f7_5=1, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, ctrl=0100, A=10, B=3.
REQ-039 alu_op=11, f3=001, imm=0x0000_0123 -> ctrl=1001, B=0x0000_0003.
REQ-040 out_ready=0, three back-to-back valid ops -> in_ready drops after second accept, third held; outputs frozen; releasing out_ready drains in order.
REQ-041 alu_op=11, f3=101, f7_5=1, then alu_op=10, f3=010 -> both ctrl=1111, illegal=1, illegal_count=2; with CNT_W=2, five illegals -> count stays 3.
REQ-042 TWO state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
REQ-043 rst asserted while state TWO -> next cycle all outputs at reset values, illegal_count=0.
